bp_be_mul_arbiter: RTL and testbench

BP_BE_MUL_ARBITER -- requirements
Module: bp_be_mul_arbiter

---
 rtl/bp_be_mul_arbiter.sv | 128 ++++++++++++
 tb/tb_bp_be_mul_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_mul_arbiter.sv
// Round-robin arbiter for two requesters sharing one fixed-latency multiplier pipe.
// A shadow pipeline tracks owner and tag so each result can be returned to its requester, and it supports per-requester flush.
module bp_be_mul_arbiter #(
    parameter int latency_p        = 4,
    parameter int tag_width_p      = 5,
    parameter int reg_data_width_p = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [1:0]                    req_v_i,
    output logic [1:0]                    req_ready_o,
    input  logic [2*tag_width_p-1:0]      req_tag_i,
    input  logic [1:0]                    req_opw_i,
    input  logic [2*reg_data_width_p-1:0] req_rs1_i,
    input  logic [2*reg_data_width_p-1:0] req_rs2_i,
    input  logic [1:0]                    flush_i,
    output logic                          mul_opw_o,
    output logic [reg_data_width_p-1:0]   mul_rs1_o,
    output logic [reg_data_width_p-1:0]   mul_rs2_o,
    input  logic [reg_data_width_p-1:0]   mul_data_i,
    output logic [1:0]                    resp_v_o,
    output logic [tag_width_p-1:0]        resp_tag_o,
    output logic [reg_data_width_p-1:0]   resp_data_o,
    output logic [5:0]                    inflight_cnt_o,
    output logic                          busy_o
);

    localparam int stages_lp = latency_p - 1;

    typedef struct packed {
        logic                   v;
        logic                   owner;
        logic [tag_width_p-1:0] tag;
    } shadow_s;

    shadow_s    shadow_r [stages_lp];
    shadow_s    shadow_last;
    logic       rr_last_r;
    logic [2:0] cnt_r [2];
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       xfer;
    logic       sel;

    // A flushed requester cannot issue, which keeps killed ops out of the pipe.
    assign eligible = req_v_i & ~flush_i & {2{reset_n_i}};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = rr_last_r ? 2'b01 : 2'b10;
        end
    end

    assign req_ready_o = grant;
    assign xfer        = |grant;
    assign sel         = grant[1];

    // Operands are zero when nothing issues to save toggling in the multiplier.
    assign mul_opw_o = xfer & (sel ? req_opw_i[1] : req_opw_i[0]);
    assign mul_rs1_o = !xfer ? '0 :
                       sel   ? req_rs1_i[2*reg_data_width_p-1:reg_data_width_p]
                             : req_rs1_i[reg_data_width_p-1:0];
    assign mul_rs2_o = !xfer ? '0 :
                       sel   ? req_rs2_i[2*reg_data_width_p-1:reg_data_width_p]
                             : req_rs2_i[reg_data_width_p-1:0];

    // NOTE: the shadow array is reset because its valid bits gate responses; data-only storage would not need it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < stages_lp; i++) begin
                shadow_r[i] <= '0;
            end
            rr_last_r <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
            shadow_r[0].v     <= xfer;
            shadow_r[0].owner <= sel;
            shadow_r[0].tag   <= !xfer ? '0 :
                                 sel   ? req_tag_i[2*tag_width_p-1:tag_width_p]
                                       : req_tag_i[tag_width_p-1:0];
            for (int i = 1; i < stages_lp; i++) begin
                shadow_r[i].v     <= shadow_r[i-1].v & ~flush_i[shadow_r[i-1].owner];
                shadow_r[i].owner <= shadow_r[i-1].owner;
                shadow_r[i].tag   <= shadow_r[i-1].tag;
            end
            if (xfer) begin
                rr_last_r <= sel;
            end
        end
    end

    assign shadow_last = shadow_r[stages_lp-1];

    // A result leaving in the flush cycle is dropped combinationally.
    assign resp_v_o[0] = shadow_last.v & ~shadow_last.owner & ~flush_i[0];
    assign resp_v_o[1] = shadow_last.v &  shadow_last.owner & ~flush_i[1];
    assign resp_tag_o  = (|resp_v_o) ? shadow_last.tag : '0;
    assign resp_data_o = mul_data_i;

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < stages_lp; i++) begin
            busy_o = busy_o | shadow_r[i].v;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r[0] <= '0;
            cnt_r[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (flush_i[k]) begin
                    cnt_r[k] <= '0;
                end else if (grant[k] && !resp_v_o[k]) begin
                    cnt_r[k] <= cnt_r[k] + 3'd1;
                end else if (!grant[k] && resp_v_o[k]) begin
                    cnt_r[k] <= cnt_r[k] - 3'd1;
                end
            end
        end
    end

    assign inflight_cnt_o = {cnt_r[1], cnt_r[0]};

endmodule

// File: tb/tb_bp_be_mul_arbiter.sv
// Directed bench for bp_be_mul_arbiter; a behavioural 3-stage multiplier pipe feeds mul_data_i.
module tb_bp_be_mul_arbiter;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [1:0]   req_v_i;
    logic [1:0]   req_ready_o;
    logic [9:0]   req_tag_i;
    logic [1:0]   req_opw_i;
    logic [127:0] req_rs1_i;
    logic [127:0] req_rs2_i;
    logic [1:0]   flush_i;
    logic         mul_opw_o;
    logic [63:0]  mul_rs1_o;
    logic [63:0]  mul_rs2_o;
    logic [63:0]  mul_data_i;
    logic [1:0]   resp_v_o;
    logic [4:0]   resp_tag_o;
    logic [63:0]  resp_data_o;
    logic [5:0]   inflight_cnt_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    bp_be_mul_arbiter #(
        .latency_p(4), .tag_width_p(5), .reg_data_width_p(64)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_tag_i(req_tag_i),
        .req_opw_i(req_opw_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .flush_i(flush_i),
        .mul_opw_o(mul_opw_o), .mul_rs1_o(mul_rs1_o), .mul_rs2_o(mul_rs2_o),
        .mul_data_i(mul_data_i),
        .resp_v_o(resp_v_o), .resp_tag_o(resp_tag_o), .resp_data_o(resp_data_o),
        .inflight_cnt_o(inflight_cnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Multiplier stand-in: result appears three edges after operands.
    logic [63:0] pipe [3];
    logic [63:0] prod_full;
    logic [31:0] prod_w;
    assign prod_full  = mul_rs1_o * mul_rs2_o;
    assign prod_w     = mul_rs1_o[31:0] * mul_rs2_o[31:0];
    assign mul_data_i = pipe[2];

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pipe[0] <= '0; pipe[1] <= '0; pipe[2] <= '0;
        end else begin
            pipe[0] <= mul_opw_o ? {{32{prod_w[31]}}, prod_w} : prod_full;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle();
        req_v_i = '0; req_tag_i = '0; req_opw_i = '0;
        req_rs1_i = '0; req_rs2_i = '0; flush_i = '0;
    endtask

    task automatic drive(input int k, input logic [4:0] tag, input logic opw,
                         input logic [63:0] a, input logic [63:0] b);
        req_v_i[k]          = 1'b1;
        req_tag_i[k*5 +: 5] = tag;
        req_opw_i[k]        = opw;
        req_rs1_i[k*64 +: 64] = a;
        req_rs2_i[k*64 +: 64] = b;
    endtask

    task automatic do_reset();
        tick(); idle(); reset_n_i = 1'b0;
        tick(); tick(); reset_n_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset_n_i = 1'b0;
        req_v_i   = 2'b11;
        #1;
        check("rst_ready", req_ready_o, 2'b00);
        check("rst_resp_v", resp_v_o, 2'b00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_cnt", inflight_cnt_o, 6'd0);
        tick(); tick(); idle(); reset_n_i = 1'b1;

        // Single op from req0: 3*5 returns three cycles later.
        for (int c = 0; c < 5; c++) begin
            tick(); idle();
            if (c == 0) drive(0, 5'd7, 1'b0, 64'd3, 64'd5);
            #1;
            if (c == 0) begin
                check("s1_ready", req_ready_o, 2'b01);
                check("s1_rs1", mul_rs1_o, 64'd3);
                check("s1_rs2", mul_rs2_o, 64'd5);
            end
            if (c >= 1 && c <= 3) check("s1_cnt0", inflight_cnt_o[2:0], 3'd1);
            if (c == 3) begin
                check("s1_resp_v", resp_v_o, 2'b01);
                check("s1_resp_tag", resp_tag_o, 5'd7);
                check("s1_resp_data", resp_data_o, 64'd15);
            end
            if (c == 4) begin
                check("s1_cnt0_end", inflight_cnt_o[2:0], 3'd0);
                check("s1_resp_v_end", resp_v_o, 2'b00);
                check("s1_tag_end", resp_tag_o, 5'd0);
                check("s1_busy_end", busy_o, 1'b0);
            end
        end

        // Lone req1 streams four ops back to back; count saturates at 3.
        for (int c = 0; c < 8; c++) begin
            tick(); idle();
            if (c < 4) drive(1, 5'(c + 1), 1'b0, 64'(c + 2), 64'd1);
            #1;
            if (c < 4) check("s2_ready", req_ready_o, 2'b10);
            if (c == 3 || c == 4) check("s2_cnt1_max", inflight_cnt_o[5:3], 3'd3);
            if (c >= 3 && c <= 6) begin
                check("s2_resp_v", resp_v_o, 2'b10);
                check("s2_resp_tag", resp_tag_o, 64'(c - 2));
                check("s2_resp_data", resp_data_o, 64'(c - 1));
            end
            if (c == 7) check("s2_cnt1_end", inflight_cnt_o[5:3], 3'd0);
        end

        // Contention after reset: grants alternate starting with req0.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick(); idle();
            if (c < 4) begin
                drive(0, 5'(10 + c), 1'b0, 64'(c + 1), 64'd2);
                drive(1, 5'(20 + c), 1'b0, 64'(c + 1), 64'd3);
            end
            #1;
            if (c < 4) check("s3_ready", req_ready_o, (c % 2 == 0) ? 2'b01 : 2'b10);
            if (c >= 3 && c <= 6) begin
                check("s3_resp_v", resp_v_o, ((c - 3) % 2 == 0) ? 2'b01 : 2'b10);
                check("s3_resp_tag", resp_tag_o, ((c - 3) % 2 == 0) ? 64'(10 + c - 3) : 64'(20 + c - 3));
                check("s3_resp_data", resp_data_o, 64'((c - 2) * (((c - 3) % 2 == 0) ? 2 : 3)));
            end
        end

        // W ops: low word of the product, sign-extended.
        for (int c = 0; c < 5; c++) begin
            tick(); idle();
            if (c == 0) drive(0, 5'd4, 1'b1, 64'h0000_0000_8000_0000, 64'd2);
            if (c == 1) drive(0, 5'd5, 1'b1, 64'h0000_0000_4000_0000, 64'd2);
            #1;
            if (c == 0) check("s4_opw", mul_opw_o, 1'b1);
            if (c == 3) begin
                check("s4_resp_v", resp_v_o, 2'b01);
                check("s4_w_zero", resp_data_o, 64'd0);
            end
            if (c == 4) check("s4_w_sext", resp_data_o, 64'hFFFF_FFFF_8000_0000);
        end

        // Flush of req1 kills its two ops but spares req0's op issued alongside.
        for (int c = 0; c < 6; c++) begin
            tick(); idle();
            if (c == 0) drive(1, 5'd1, 1'b0, 64'd5, 64'd5);
            if (c == 1) drive(1, 5'd2, 1'b0, 64'd6, 64'd6);
            if (c == 2) begin
                drive(0, 5'd9, 1'b0, 64'd7, 64'd3);
                drive(1, 5'd3, 1'b0, 64'd1, 64'd1);
                flush_i = 2'b10;
            end
            #1;
            if (c == 2) begin
                check("s5_ready_flush", req_ready_o, 2'b01);
                check("s5_rs1", mul_rs1_o, 64'd7);
            end
            if (c == 3) begin
                check("s5_cnt1", inflight_cnt_o[5:3], 3'd0);
                check("s5_cnt0", inflight_cnt_o[2:0], 3'd1);
            end
            if (c == 3 || c == 4) check("s5_no_resp", resp_v_o, 2'b00);
            if (c == 5) begin
                check("s5_resp_v", resp_v_o, 2'b01);
                check("s5_resp_tag", resp_tag_o, 5'd9);
                check("s5_resp_data", resp_data_o, 64'd21);
            end
        end

        // Flush in the very cycle a req1 result returns.
        for (int c = 0; c < 5; c++) begin
            tick(); idle();
            if (c == 0) drive(1, 5'd6, 1'b0, 64'd2, 64'd2);
            if (c == 3) begin
                drive(1, 5'd7, 1'b0, 64'd9, 64'd9);
                flush_i = 2'b10;
            end
            #1;
            if (c == 2) check("s6_cnt1_pre", inflight_cnt_o[5:3], 3'd1);
            if (c == 3) begin
                check("s6_resp_suppr", resp_v_o, 2'b00);
                check("s6_tag_suppr", resp_tag_o, 5'd0);
                check("s6_ready_flush", req_ready_o, 2'b00);
                check("s6_gate_rs1", mul_rs1_o, 64'd0);
            end
            if (c == 4) begin
                check("s6_cnt1", inflight_cnt_o[5:3], 3'd0);
                check("s6_busy", busy_o, 1'b0);
            end
        end

        // Reset pulse in the middle of a stream discards everything in flight.
        for (int c = 0; c < 8; c++) begin
            tick(); idle();
            if (c < 3) drive(0, 5'(c + 1), 1'b0, 64'd1, 64'd1);
            if (c == 2) reset_n_i = 1'b0;
            if (c == 3) reset_n_i = 1'b1;
            #1;
            if (c == 2) begin
                check("s7_ready_rst", req_ready_o, 2'b00);
                check("s7_busy_rst", busy_o, 1'b0);
                check("s7_cnt_rst", inflight_cnt_o, 6'd0);
                check("s7_resp_rst", resp_v_o, 2'b00);
            end
            if (c >= 3) check("s7_no_resp", resp_v_o, 2'b00);
            if (c == 7) check("s7_busy_end", busy_o, 1'b0);
        end

        // No requests: operands gated to zero.
        for (int c = 0; c < 3; c++) begin
            tick(); idle();
            req_rs1_i = {2{64'hDEAD_BEEF_0000_1234}};
            req_rs2_i = {2{64'h1111_2222_3333_4444}};
            req_opw_i = 2'b11;
            #1;
            check("s8_rs1", mul_rs1_o, 64'd0);
            check("s8_rs2", mul_rs2_o, 64'd0);
            check("s8_opw", mul_opw_o, 1'b0);
            check("s8_ready", req_ready_o, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
